counter_sched: RTL

- Shares one 3-bit down-counter timer between NUM_REQ requesters.
- Arbitrates pending requests round-robin, then sequences the counter through one job: load the requested value, pulse count enable at the prescaled tick rate, wait for done.
- Reports completion to the owning requester.
- Sits between requester logic and the single `Counter` instance; drives all of that counter's control inputs.

---
 rtl/counter_sched_pkg.sv | 23 ++
 rtl/counter_sched_rr_arbiter.sv | 37 +++
 rtl/counter_sched.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/counter_sched_pkg.sv
// Purpose : shared types and constants for the counter scheduler.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, default counter width, watchdog limit helper.
package counter_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    localparam int DEFAULT_WIDTH = 3;

    // RUN cycles a job may take before the watchdog gives up on cnt_done.
    // The longest legal job needs 2**width enables, each tick_div cycles apart;
    // the +4 is slack for load/done-register latency.
    function automatic int timeout_limit(input int width, input int tick_div);
        return (2 ** width) * tick_div + 4;
    endfunction

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// Purpose : round-robin pick of one requester, searching upward from ptr_i.
// Latency : combinational.
// Backpressure: none; the caller decides when the grant is taken.
// Ports   : req_i request vector, ptr_i first index to consider,
//           gnt_o one-hot grant, idx_o grant index, vld_o any request present.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      idx_o,
    output logic               vld_o
);

    logic [IW-1:0] k;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        k     = '0;
        // Walk the requesters in rotated order; the first hit wins.
        for (int i = 0; i < NUM_REQ; i++) begin
            k = IW'((int'(ptr_i) + i) % NUM_REQ);
            if (!vld_o && req_i[k]) begin
                vld_o = 1'b1;
                idx_o = k;
            end
        end
        if (vld_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/counter_sched.sv
// Purpose : shares one down-counter between NUM_REQ requesters, one job at a time.
// Latency : ack/cnt_load 1 cycle after grant; cmpl at (V+1)*TICK_DIV+3 cycles.
// Backpressure: requesters hold req until ack; no new grant until the job ends.
// Ports   : req/req_val/abort from requesters; ack/cmpl/err/busy/owner back to them;
//           cnt_load/cnt_count_to/cnt_en drive the counter, cnt_done returns from it.
// Option  : COUNTER_SCHED_TIMEOUT_EN adds a RUN-state watchdog that ends a job with err.
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int TICK_DIV = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_val,
    input  logic                       abort,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REQ-1:0]         cmpl,
    output logic                       err,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       cnt_load,
    output logic [WIDTH-1:0]           cnt_count_to,
    output logic                       cnt_en,
    input  logic                       cnt_done
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = WIDTH + 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_e                 state_q, state_d;
    logic [IW-1:0]          owner_q, owner_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [WIDTH-1:0]       count_to_q, count_to_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic                   err_q, err_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic [CW-1:0]          en_cnt_q, en_cnt_d;

    logic [NUM_REQ-1:0]     arb_gnt;
    logic [IW-1:0]          arb_idx;
    logic                   arb_vld;
    logic [WIDTH-1:0]       val_slice [NUM_REQ];
    logic                   tick;
    logic                   en_fire;
    logic                   wd_expire;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign val_slice[i] = req_val[i*WIDTH +: WIDTH];
    end

    // ptr_q holds (last owner + 1) mod NUM_REQ, so reset value 0 favours req[0].
    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    assign tick = (presc_q == PRESC_LAST);
    // A value V needs exactly V+1 enables; stop pulsing after that so the
    // counter is not clocked again while cnt_done travels back to us.
    assign en_fire = (state_q == ST_RUN) && tick && (en_cnt_q <= {1'b0, count_to_q});

`ifdef COUNTER_SCHED_TIMEOUT_EN
    localparam int WD_LIMIT = timeout_limit(WIDTH, TICK_DIV);
    localparam int WDW      = $clog2(WD_LIMIT);
    logic [WDW-1:0] wd_q, wd_d;
    // wd_q counts RUN cycles already spent; expire on the WD_LIMIT-th one.
    assign wd_expire = (wd_q == WDW'(WD_LIMIT - 1));
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        count_to_d = count_to_q;
        ack_d      = '0;
        err_d      = 1'b0;
        presc_d    = presc_q;
        en_cnt_d   = en_cnt_q;
`ifdef COUNTER_SCHED_TIMEOUT_EN
        wd_d       = wd_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    owner_d    = arb_idx;
                    ptr_d      = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + IW'(1);
                    count_to_d = val_slice[arb_idx];
                    ack_d      = arb_gnt;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // cnt_done may still be high from the previous job; not looked at here.
                presc_d  = '0;
                en_cnt_d = '0;
`ifdef COUNTER_SCHED_TIMEOUT_EN
                wd_d     = '0;
`endif
                if (abort) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // done takes priority over a coincident abort
                if (cnt_done) begin
                    state_d = ST_FIN;
                end else if (abort || wd_expire) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (en_fire) begin
                        en_cnt_d = en_cnt_q + CW'(1);
                    end
`ifdef COUNTER_SCHED_TIMEOUT_EN
                    wd_d = wd_q + WDW'(1);
`endif
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            count_to_q <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            presc_q    <= '0;
            en_cnt_q   <= '0;
`ifdef COUNTER_SCHED_TIMEOUT_EN
            wd_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            count_to_q <= count_to_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            presc_q    <= presc_d;
            en_cnt_q   <= en_cnt_d;
`ifdef COUNTER_SCHED_TIMEOUT_EN
            wd_q       <= wd_d;
`endif
        end
    end

    assign ack          = ack_q;
    assign err          = err_q;
    assign cmpl         = (state_q == ST_FIN) ? (NUM_REQ'(1) << owner_q) : '0;
    assign busy         = (state_q != ST_IDLE);
    assign owner        = owner_q;
    assign cnt_load     = (state_q == ST_LOAD);
    assign cnt_count_to = count_to_q;
    assign cnt_en       = en_fire;

endmodule
